// File: rtl/fab_clk_rst_sequencer_pkg.sv
// fab_clk_pkg: shared types and constants for the fabric clock/reset sequencer.
//   seq_state_t : sequencer FSM state encoding
//   us_div()    : PCLK cycles per microsecond for a given clock frequency
//   MS_DIV      : microsecond ticks per millisecond tick
//   LOSS_MAX    : saturation value of the lock-loss counter
package fab_clk_pkg;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_STABLE = 2'd1,
      ST_RUN    = 2'd2
   } seq_state_t;

   localparam int unsigned MS_DIV   = 1000;
   localparam logic [7:0]  LOSS_MAX = 8'hFF;

   // clk_freq_hz is expected to be an integer multiple of 1 MHz.
   function automatic int unsigned us_div(input int unsigned clk_freq_hz);
      return clk_freq_hz / 1_000_000;
   endfunction

endpackage

// File: rtl/fab_clk_rst_sequencer_sync_ff.sv
// sync_ff: multi-flop synchronizer for a single asynchronous level signal.
//   clk_sys : destination clock
//   rst_b   : asynchronous active-low reset, clears every stage to 0
//   d       : asynchronous input
//   q       : d after STAGES flops in the clk_sys domain
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stage;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         stage <= '0;
      end else begin
         stage <= {stage[STAGES-2:0], d};
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/fab_clk_rst_sequencer.sv
// fab_clk_rst_sequencer: qualifies the CCC LOCK signal, releases the fabric
// reset once LOCK has been stable long enough, and generates 1 us / 1 ms
// strobes while the fabric is running.
//   PCLK        : fabric clock from the CCC
//   PRESETN     : asynchronous active-low reset
//   LOCK        : CCC lock, asynchronous to PCLK
//   FAB_RESET_N : fabric reset, high only in RUN
//   READY       : high only in RUN
//   TICK_US     : one-cycle strobe every microsecond in RUN
//   TICK_MS     : one-cycle strobe every millisecond in RUN, coincident with TICK_US
//   LOSS_CNT    : saturating count of RUN -> WAIT lock losses
//
// state  | meaning
// WAIT   | fabric held in reset, waiting for synchronized LOCK
// STABLE | LOCK seen, counting consecutive high cycles
// RUN    | fabric released, READY high, strobes running
module fab_clk_rst_sequencer
   import fab_clk_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ        = 100_000_000,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter bit          USE_LOCK           = 1'b1
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   input  logic       LOCK,
   output logic       FAB_RESET_N,
   output logic       READY,
   output logic       TICK_US,
   output logic       TICK_MS,
   output logic [7:0] LOSS_CNT
);

   localparam int unsigned US_DIV = us_div(CLK_FREQ_HZ);
   localparam int unsigned CNT_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int unsigned US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [US_W-1:0]  US_LOAD  = US_W'(US_DIV - 1);
   localparam logic [9:0]       MS_LOAD  = 10'(MS_DIV - 1);

   logic             lock_s;
   seq_state_t       state;
   logic [CNT_W-1:0] stable_cnt;
   logic [US_W-1:0]  us_cnt;
   logic [9:0]       ms_cnt;
   logic             run;

   generate
      if (USE_LOCK) begin : g_sync
         sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
            .clk_sys (PCLK),
            .rst_b   (PRESETN),
            .d       (LOCK),
            .q       (lock_s)
         );
      end else begin : g_bypass
         // CCC in bypass: the clock is always usable.
         logic unused_lock;
         assign unused_lock = LOCK;
         assign lock_s      = 1'b1;
      end
   endgenerate

   assign run = (state == ST_RUN);

   // Qualification timer counts down; leaving STABLE at zero means it never wraps.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state       <= ST_WAIT;
         stable_cnt  <= '0;
         FAB_RESET_N <= 1'b0;
         READY       <= 1'b0;
         LOSS_CNT    <= '0;
      end else begin
         case (state)
            ST_WAIT: begin
               stable_cnt  <= CNT_LOAD;
               FAB_RESET_N <= 1'b0;
               READY       <= 1'b0;
               if (lock_s) state <= ST_STABLE;
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state      <= ST_WAIT;
                  stable_cnt <= CNT_LOAD;
               end else if (stable_cnt == '0) begin
                  state       <= ST_RUN;
                  FAB_RESET_N <= 1'b1;
                  READY       <= 1'b1;
               end else begin
                  stable_cnt <= stable_cnt - 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state       <= ST_WAIT;
                  FAB_RESET_N <= 1'b0;
                  READY       <= 1'b0;
                  if (LOSS_CNT != LOSS_MAX) LOSS_CNT <= LOSS_CNT + 1'b1;
               end
            end
            default: begin
               state       <= ST_WAIT;
               stable_cnt  <= CNT_LOAD;
               FAB_RESET_N <= 1'b0;
               READY       <= 1'b0;
            end
         endcase
      end
   end

   // Prescalers are down-counters whose idle value is their reload value.
   // Gating on the registered state lets a tick fire on the lock-loss edge;
   // the counters reload on the following cycle.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         us_cnt  <= US_LOAD;
         ms_cnt  <= MS_LOAD;
         TICK_US <= 1'b0;
         TICK_MS <= 1'b0;
      end else if (!run) begin
         us_cnt  <= US_LOAD;
         ms_cnt  <= MS_LOAD;
         TICK_US <= 1'b0;
         TICK_MS <= 1'b0;
      end else begin
         TICK_US <= (us_cnt == '0);
         TICK_MS <= (us_cnt == '0) && (ms_cnt == '0);
         if (us_cnt == '0) begin
            us_cnt <= US_LOAD;
            ms_cnt <= (ms_cnt == '0) ? MS_LOAD : ms_cnt - 1'b1;
         end else begin
            us_cnt <= us_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fab_clk_rst_sequencer.sv
// Testbench for fab_clk_rst_sequencer: one instance with LOCK qualification,
// one with LOCK bypassed (LOCK tied low), both on a shared clock and reset.
`timescale 1ns/1ps
module tb_fab_clk_rst_sequencer;

   localparam int F      = 5_000_000;
   localparam int L      = 16;
   localparam int S      = 2;
   localparam int US     = F / 1_000_000;
   localparam int MS_CYC = US * 1000;

   logic PCLK = 1'b0;
   logic PRESETN = 1'b0;
   logic LOCK = 1'b0;
   logic lock_tie = 1'b0;

   logic       fab_a, ready_a, tus_a, tms_a;
   logic [7:0] loss_a;
   logic       fab_b, ready_b, tus_b, tms_b;
   logic [7:0] loss_b;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   fab_clk_rst_sequencer #(
      .CLK_FREQ_HZ(F), .LOCK_STABLE_CYCLES(L), .SYNC_STAGES(S), .USE_LOCK(1'b1)
   ) dut_a (
      .PCLK(PCLK), .PRESETN(PRESETN), .LOCK(LOCK),
      .FAB_RESET_N(fab_a), .READY(ready_a), .TICK_US(tus_a), .TICK_MS(tms_a),
      .LOSS_CNT(loss_a)
   );

   fab_clk_rst_sequencer #(
      .CLK_FREQ_HZ(F), .LOCK_STABLE_CYCLES(L), .SYNC_STAGES(S), .USE_LOCK(1'b0)
   ) dut_b (
      .PCLK(PCLK), .PRESETN(PRESETN), .LOCK(lock_tie),
      .FAB_RESET_N(fab_b), .READY(ready_b), .TICK_US(tus_b), .TICK_MS(tms_b),
      .LOSS_CNT(loss_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: ready once synchronized LOCK has been sampled high on
   // L+1 consecutive edges; ticks from the number of edges spent ready.
   logic [S-1:0] hist;
   bit ls_m;
   int lock_run, k_a, loss_m, edges_b, k_b;
   bit ready_m, tus_m, tms_m, ready_bm, tus_bm, tms_bm;

   always @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         hist = '0; lock_run = 0; k_a = 0; loss_m = 0; edges_b = 0; k_b = 0;
         ready_m = 0; tus_m = 0; tms_m = 0; ready_bm = 0; tus_bm = 0; tms_bm = 0;
      end else begin
         ls_m = hist[S-1];
         hist = {hist[S-2:0], LOCK};
         k_a   = ready_m ? k_a + 1 : 0;
         tus_m = ready_m && (k_a % US == 0);
         tms_m = ready_m && (k_a % MS_CYC == 0);
         if (ready_m && !ls_m && loss_m < 255) loss_m++;
         lock_run = ls_m ? lock_run + 1 : 0;
         ready_m  = (lock_run >= L + 1);
         k_b    = ready_bm ? k_b + 1 : 0;
         tus_bm = ready_bm && (k_b % US == 0);
         tms_bm = ready_bm && (k_b % MS_CYC == 0);
         edges_b++;
         ready_bm = (edges_b >= L + 1);
      end
   end

   always @(negedge PCLK) begin
      if (PRESETN) begin
         chk("fab_a",   fab_a,   ready_m);
         chk("ready_a", ready_a, ready_m);
         chk("tus_a",   tus_a,   tus_m);
         chk("tms_a",   tms_a,   tms_m);
         chk("loss_a",  loss_a,  loss_m);
         chk("fab_b",   fab_b,   ready_bm);
         chk("ready_b", ready_b, ready_bm);
         chk("tus_b",   tus_b,   tus_bm);
         chk("tms_b",   tms_b,   tms_bm);
         chk("loss_b",  loss_b,  0);
      end
   end

   function automatic bit sig(input int sel);
      case (sel)
         0:       return fab_a;
         1:       return ready_b;
         2:       return tus_a;
         default: return tms_a;
      endcase
   endfunction

   // Counts rising edges until the selected output equals val; -1 on timeout.
   task automatic count_until(input int sel, input bit val, input int limit, output int n);
      n = 0;
      while (n < limit) begin
         @(posedge PCLK); #1;
         n++;
         if (sig(sel) == val) return;
      end
      n = -1;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge PCLK);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      PRESETN = 1'b0;
      LOCK    = 1'b0;
      cyc(3);
      chk("rst_fab_a",   fab_a,   0);
      chk("rst_ready_a", ready_a, 0);
      chk("rst_tus_a",   tus_a,   0);
      chk("rst_tms_a",   tms_a,   0);
      chk("rst_loss_a",  loss_a,  0);
      chk("rst_ready_b", ready_b, 0);

      // Bypass instance: released L+1 edges after reset deasserts.
      PRESETN = 1'b1;
      count_until(1, 1'b1, 40, n);
      chk("t6_ready_b_latency", n, 17);

      // LOCK rises and holds.
      cyc(2);
      LOCK = 1'b1;
      count_until(0, 1'b1, 60, n);
      chk("t1_release_latency", n, 19);
      chk("t1_ready", ready_a, 1);
      chk("t1_loss", loss_a, 0);

      // Strobe spacing.
      count_until(2, 1'b1, 20, n);
      chk("t4_first_us", n, US);
      count_until(3, 1'b1, MS_CYC + 10, n);
      chk("t4_first_ms", n, MS_CYC - US);
      chk("t4_ms_with_us", tus_a, 1);
      count_until(2, 1'b1, 20, n);
      chk("t4_us_period", n, US);

      // Lock loss in RUN, then relock.
      cyc(1);
      LOCK = 1'b0;
      count_until(0, 1'b0, 20, n);
      chk("t3_drop_latency", n, 3);
      chk("t3_loss", loss_a, 1);
      cyc(2);
      chk("t3_tick_cleared", tus_a, 0);
      LOCK = 1'b1;
      count_until(0, 1'b1, 60, n);
      chk("t3_relock_latency", n, 19);

      // One-cycle glitch during qualification restarts it.
      cyc(1);
      LOCK = 1'b0;
      count_until(0, 1'b0, 20, n);
      cyc(3);
      LOCK = 1'b1;
      cyc(10);
      LOCK = 1'b0;
      cyc(1);
      LOCK = 1'b1;
      count_until(0, 1'b1, 60, n);
      chk("t2_restart_latency", n, 19);
      chk("t2_loss", loss_a, 2);

      // Saturation of the loss counter.
      for (int i = 0; i < 300; i++) begin
         cyc(1);
         LOCK = 1'b0;
         cyc(4);
         LOCK = 1'b1;
         cyc(21);
      end
      chk("t5_loss_sat", loss_a, 255);
      chk("t5_ready", ready_a, 1);

      // Reset while running drops outputs immediately.
      PRESETN = 1'b0;
      #1;
      chk("t5_rst_run_fab",   fab_a,   0);
      chk("t5_rst_run_ready", ready_a, 0);
      chk("t5_rst_run_loss",  loss_a,  0);
      chk("t5_rst_run_rdy_b", ready_b, 0);
      cyc(2);
      PRESETN = 1'b1;

      // Reset while qualifying.
      cyc(8);
      PRESETN = 1'b0;
      #1;
      chk("t5_rst_stable_fab",   fab_a,   0);
      chk("t5_rst_stable_ready", ready_a, 0);
      chk("t5_rst_stable_tus",   tus_a,   0);
      chk("t5_rst_stable_loss",  loss_a,  0);
      cyc(2);
      PRESETN = 1'b1;
      count_until(0, 1'b1, 60, n);
      chk("t5_post_rst_latency", n, 19);

      cyc(30);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
